// File: rtl/trig_lut_scheduler_pkg.sv
// Shared definitions for the reciprocal-trig LUT scheduler: function codes,
// angle constants, FSM state encoding and the function-to-enable decode.
package trig_lut_scheduler_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;

  localparam logic [1:0] FUNC_CSC = 2'd0;
  localparam logic [1:0] FUNC_SEC = 2'd1;
  localparam logic [1:0] FUNC_COT = 2'd2;

  localparam int unsigned DEG_90  = 90;
  localparam int unsigned DEG_360 = 360;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // One-hot LUT enable for a function code; illegal code enables nothing.
  function automatic logic [2:0] func_onehot(input logic [1:0] func);
    case (func)
      FUNC_CSC: return 3'b001;
      FUNC_SEC: return 3'b010;
      FUNC_COT: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/trig_lut_scheduler_if.sv
// Requester and response handshake bundle of the LUT scheduler.
// master: angle-issuing front end / response consumer; slave: the scheduler.
interface trig_lut_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    req0_valid;
  logic                    req0_ready;
  logic [DATA_WIDTH-1:0]   req0_angle;
  logic [1:0]              req0_func;

  logic                    req1_valid;
  logic                    req1_ready;
  logic [DATA_WIDTH-1:0]   req1_angle;
  logic [1:0]              req1_func;

  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_id;
  logic                    resp_err;
  logic [2*DATA_WIDTH-1:0] resp_data;

  modport master (
    output req0_valid, req0_angle, req0_func,
    output req1_valid, req1_angle, req1_func,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_err, resp_data
  );

  modport slave (
    input  req0_valid, req0_angle, req0_func,
    input  req1_valid, req1_angle, req1_func,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_err, resp_data
  );

endinterface

// File: rtl/trig_rr_arbiter.sv
// Two-way round-robin arbiter. The pointer names the requester preferred
// when both are valid; it moves to the other requester on each acceptance.
module trig_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  // Grant selection: sole requester wins, contention resolved by the pointer.
  always_comb begin
    grant_id = 1'b0;
    grant    = '0;
    if (req == 2'b11) begin
      grant_id = ptr;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
    if (req != '0) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  // Pointer update: after an acceptance, favour the requester not just served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/trig_lut_scheduler.sv
// Shares the csc/sec/cot LUT bank between two requesters: arbitrates,
// reduces the angle to quadrant + reference angle by repeated subtraction,
// sequences the LUT enable and returns the captured result with backpressure.
module trig_lut_scheduler
  import trig_lut_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned LUT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  trig_lut_scheduler_if.slave     bus,
  output logic [2:0]              lut_en,
  output logic [1:0]              lut_quadrant,
  output logic [DATA_WIDTH-1:0]   lut_angle,
  input  logic [2*DATA_WIDTH-1:0] csc_data,
  input  logic [2*DATA_WIDTH-1:0] sec_data,
  input  logic [2*DATA_WIDTH-1:0] cot_data
);

  localparam logic [DATA_WIDTH-1:0] ANG_90  = DATA_WIDTH'(DEG_90);
  localparam logic [DATA_WIDTH-1:0] ANG_360 = DATA_WIDTH'(DEG_360);
  localparam logic [2:0]            LAT     = 3'(LUT_LATENCY);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   rem;
  logic [1:0]              q;
  logic [1:0]              func_r;
  logic [2:0]              cnt;
  logic                    resp_valid_r;
  logic                    resp_id_r;
  logic                    resp_err_r;
  logic [2*DATA_WIDTH-1:0] resp_data_r;

  logic [1:0]              req_valid;
  logic [1:0]              grant;
  logic                    grant_id;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   acc_angle;
  logic [1:0]              acc_func;
  logic                    acc_err;
  logic [2*DATA_WIDTH-1:0] lut_data;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  trig_rr_arbiter u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign accept         = (state == ST_IDLE) && (grant != '0);
  assign bus.req0_ready = (state == ST_IDLE) && grant[0];
  assign bus.req1_ready = (state == ST_IDLE) && grant[1];

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_data  = resp_data_r;

  // Granted request fields and legality.
  always_comb begin
    acc_angle = grant_id ? bus.req1_angle : bus.req0_angle;
    acc_func  = grant_id ? bus.req1_func  : bus.req0_func;
    acc_err   = (acc_angle >= ANG_360) || (acc_func == 2'd3);
  end

  // LUT output of the function in flight.
  always_comb begin
    case (func_r)
      FUNC_CSC: lut_data = csc_data;
      FUNC_SEC: lut_data = sec_data;
      default:  lut_data = cot_data;
    endcase
  end

  // Request sequencing: accept, reduce, issue, wait for LUT, respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      rem          <= '0;
      q            <= '0;
      func_r       <= '0;
      cnt          <= '0;
      lut_en       <= '0;
      lut_quadrant <= '0;
      lut_angle    <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            resp_id_r <= grant_id;
            func_r    <= acc_func;
            rem       <= acc_angle;
            q         <= '0;
            if (acc_err) begin
              resp_err_r  <= 1'b1;
              resp_data_r <= '0;
              state       <= ST_RESP;
            end else begin
              resp_err_r <= 1'b0;
              state      <= ST_REDUCE;
            end
          end
        end
        ST_REDUCE: begin
          if (rem >= ANG_90) begin
            rem <= rem - ANG_90;
            q   <= q + 2'd1;
          end else begin
            // Outputs are registered, so they are loaded on entry to ISSUE.
            lut_quadrant <= q;
            lut_angle    <= q[0] ? (ANG_90 - rem) : rem;
            lut_en       <= func_onehot(func_r);
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == LAT) begin
            resp_data_r  <= lut_data;
            lut_en       <= '0;
            resp_valid_r <= 1'b1;
            state        <= ST_RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_RESP: begin
          // Error requests enter with resp_valid low; it rises one cycle later.
          if (!resp_valid_r) begin
            resp_valid_r <= 1'b1;
          end else if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Scoreboard bench for trig_lut_scheduler: expected responses are queued on
// acceptance and compared when the response handshake completes.
module tb_trig_lut_scheduler;
  import trig_lut_scheduler_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 1;

  typedef struct {
    logic        id;
    logic        err;
    logic [63:0] data;
    logic [2:0]  en;
    logic [1:0]  quad;
    logic [31:0] ang;
    int unsigned lat;
    int unsigned acc_cycle;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [2:0]    lut_en;
  logic [1:0]    lut_quadrant;
  logic [DW-1:0] lut_angle;
  logic [63:0]   csc_data, sec_data, cot_data;

  exp_t        sb[$];
  bit          grant_log[$];
  exp_t        acc_e;
  exp_t        pop_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cycle  = 0;
  int unsigned csc_cnt, sec_cnt, cot_cnt;
  logic        prev_rv;
  logic [2:0]  prev_en;
  int unsigned en_cycles;

  trig_lut_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  trig_lut_scheduler #(.DATA_WIDTH(DW), .LUT_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .lut_en       (lut_en),
    .lut_quadrant (lut_quadrant),
    .lut_angle    (lut_angle),
    .csc_data     (csc_data),
    .sec_data     (sec_data),
    .cot_data     (cot_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // LUT model: data becomes valid LAT enabled edges after its enable rises.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csc_cnt <= 0; sec_cnt <= 0; cot_cnt <= 0;
    end else begin
      csc_cnt <= lut_en[0] ? csc_cnt + 1 : 0;
      sec_cnt <= lut_en[1] ? sec_cnt + 1 : 0;
      cot_cnt <= lut_en[2] ? cot_cnt + 1 : 0;
    end
  end
  assign csc_data = (csc_cnt >= LAT) ? 64'h4000000000000000 : 64'hBAD0BAD0BAD0BAD0;
  assign sec_data = (sec_cnt >= LAT) ? {16'h5EC0, 14'h0, lut_quadrant, lut_angle} : 64'hBAD1BAD1BAD1BAD1;
  assign cot_data = (cot_cnt >= LAT) ? {16'hC070, 14'h0, lut_quadrant, lut_angle} : 64'hBAD2BAD2BAD2BAD2;

  function automatic exp_t model(input logic id, input logic [31:0] angle, input logic [1:0] func);
    exp_t e;
    int unsigned q, r;
    e.id = id;
    e.err = (angle >= 360) || (func == 2'd3);
    e.acc_cycle = 0;
    if (e.err) begin
      e.data = '0; e.en = '0; e.quad = '0; e.ang = '0; e.lat = 1;
    end else begin
      q = angle / 90;
      r = angle % 90;
      e.quad = q[1:0];
      e.ang  = (q % 2 == 1) ? 90 - r : r;
      e.lat  = q + 3 + LAT;
      case (func)
        2'd0:    begin e.en = 3'b001; e.data = 64'h4000000000000000; end
        2'd1:    begin e.en = 3'b010; e.data = {16'h5EC0, 14'h0, e.quad, e.ang}; end
        default: begin e.en = 3'b100; e.data = {16'hC070, 14'h0, e.quad, e.ang}; end
      endcase
    end
    return e;
  endfunction

  // Acceptance monitor: the handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        acc_e = model(1'b0, bus.req0_angle, bus.req0_func);
        acc_e.acc_cycle = cycle + 1;
        sb.push_back(acc_e);
        grant_log.push_back(1'b0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        acc_e = model(1'b1, bus.req1_angle, bus.req1_func);
        acc_e.acc_cycle = cycle + 1;
        sb.push_back(acc_e);
        grant_log.push_back(1'b1);
      end
    end
  end

  // LUT-side and response-side monitor.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rv = 1'b0; prev_en = '0; en_cycles = 0;
    end else begin
      if (lut_en != '0) begin
        en_cycles++;
        if (prev_en == '0) begin
          if (sb.size() == 0) check_eq("lut_en_no_req", lut_en, 0);
          else begin
            check_eq("lut_en", lut_en, sb[0].en);
            check_eq("lut_quad", lut_quadrant, sb[0].quad);
            check_eq("lut_angle", lut_angle, sb[0].ang);
          end
        end
      end else if (prev_en != '0) begin
        check_eq("lut_en_len", en_cycles, LAT + 2);
        en_cycles = 0;
      end
      prev_en = lut_en;

      if (bus.resp_valid && !prev_rv) begin
        if (sb.size() == 0) check_eq("resp_no_req", bus.resp_valid, 0);
        else check_eq("latency", cycle - sb[0].acc_cycle, sb[0].lat);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) check_eq("resp_extra", bus.resp_valid, 0);
        else begin
          pop_e = sb.pop_front();
          check_eq("resp_id", bus.resp_id, pop_e.id);
          check_eq("resp_err", bus.resp_err, pop_e.err);
          check_eq("resp_data", bus.resp_data, pop_e.data);
        end
      end
      prev_rv = bus.resp_valid;
    end
  end

  task automatic send(input bit id, input logic [31:0] angle, input logic [1:0] func);
    int unsigned n = 0;
    bit done = 0;
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_angle = angle; bus.req0_func = func;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_angle = angle; bus.req1_func = func;
    end
    while (!done) begin
      @(negedge clk);
      if ((id == 1'b0) ? bus.req0_ready : bus.req1_ready) done = 1;
      else begin
        n++;
        if (n > 200) begin
          check_eq("send_timeout", (id == 1'b0) ? bus.req0_ready : bus.req1_ready, 1);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || bus.resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned sweep[5];
    sweep = '{0, 90, 150, 210, 300};
    reset_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_angle = '0; bus.req0_func = '0;
    bus.req1_valid = 1'b0; bus.req1_angle = '0; bus.req1_func = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {lut_en, lut_quadrant, bus.resp_valid, bus.resp_id, bus.resp_err,
                          bus.req0_ready, bus.req1_ready}, 0);
    check_eq("rst_angle", lut_angle, 0);
    check_eq("rst_data", bus.resp_data, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_ctrl", {lut_en, bus.resp_valid, bus.req0_ready, bus.req1_ready}, 0);

    // Arbitration: both requesters held valid
    bus.req0_valid = 1'b1; bus.req0_angle = 45;  bus.req0_func = FUNC_COT;
    bus.req1_valid = 1'b1; bus.req1_angle = 120; bus.req1_func = FUNC_CSC;
    @(negedge clk);
    check_eq("first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    n = 0;
    while (grant_log.size() < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_drain();
    check_eq("arb_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq("arb_order", grant_log[i], i % 2);

    // csc 30 on requester 0
    send(1'b0, 30, FUNC_CSC);
    wait_drain();

    // Quadrant mapping for sec
    for (int i = 0; i < 5; i++) begin
      send(i[0], sweep[i], FUNC_SEC);
      wait_drain();
    end

    // Boundaries just inside the legal range
    send(1'b1, 359, FUNC_COT);
    wait_drain();
    send(1'b0, 89, FUNC_COT);
    wait_drain();

    // Error requests
    send(1'b1, 360, FUNC_SEC);
    wait_drain();
    send(1'b0, 10, 2'd3);
    wait_drain();
    send(1'b0, 32'hFFFF_FFFF, FUNC_CSC);
    wait_drain();

    // Backpressure with a competing request pending
    bus.resp_ready = 1'b0;
    send(1'b0, 45, FUNC_SEC);
    fork
      send(1'b1, 60, FUNC_COT);
    join_none
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_rise", bus.resp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_valid", bus.resp_valid, 1);
      if (sb.size() != 0) check_eq("bp_data", bus.resp_data, sb[0].data);
      check_eq("bp_nogrant", {bus.req1_ready, bus.req0_ready}, 0);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    n = 0;
    while (bus.req1_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    wait_drain();

    // Reset pulsed during WAIT
    send(1'b0, 300, FUNC_SEC);
    n = 0;
    while (lut_en == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_wait_en", lut_en, 0);
    check_eq("rst_wait_rv", bus.resp_valid, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", {bus.resp_valid, lut_en}, 0);
    send(1'b1, 210, FUNC_COT);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_lut_scheduler.md
Name: trig_lut_scheduler

Overview:
- Shares one bank of reciprocal-trig LUTs (cosecant, secant, cotangent) between two requesters.
- Per request: round-robin arbitration, iterative reduction of the 0..359 degree angle to quadrant plus reference angle, then LUT enable sequencing.
- Captures the 64-bit DFPU result and returns it on a single response channel with backpressure.
- Sits between the angle-issuing front end and the per-function LUTs; the LUTs apply the sign from the quadrant input.

Parameters:
- DATA_WIDTH, `DATA_WIDTH from src/defines.v (32), width of the angle fields.
- LUT_LATENCY, 1, cycles from the first enabled edge until LUT data_out is valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_angle  in  DATA_WIDTH  angle in degrees, unsigned.
- req0_func  in  2  function: 0 = csc, 1 = sec, 2 = cot, 3 = illegal.
- req1_valid, req1_ready, req1_angle, req1_func: same as requester 0.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester that owns the response.
- resp_err  out  1  angle >= 360 or func == 3.
- resp_data  out  2*DATA_WIDTH  DFPU result.
- lut_en  out  3  one-hot enable: bit0 csc, bit1 sec, bit2 cot.
- lut_quadrant  out  2  quadrant to the LUTs.
- lut_angle  out  DATA_WIDTH  reference angle 0..90 to the LUTs.
- csc_data, sec_data, cot_data  in  2*DATA_WIDTH  LUT outputs.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours requester 0.
- Reset is asynchronous. Reset asserted mid-operation drops the in-flight request and any pending response silently.
- States: IDLE, REDUCE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the valid requester. If both are valid, the grant goes to the requester not granted last.
  - reqN_ready is asserted combinationally for the granted requester only. Acceptance happens at the edge where valid && ready.
  - On acceptance: latch id, func and angle into rem; set q = 0; toggle the pointer to the other requester.
  - If angle >= 360 or func == 3: go to RESP with resp_err = 1 and resp_data = 0. No lut_en is issued.
  - Otherwise go to REDUCE.
- REDUCE, one subtraction per cycle:
  - If rem >= 90: rem -= 90 and q += 1.
  - Else go to ISSUE.
  - This takes q+1 cycles.
- ISSUE:
  - lut_quadrant = q.
  - lut_angle = rem when q is even, 90 - rem when q is odd. This is valid for all three functions, e.g. 150 gives q = 1, angle 30; 90 gives q = 1, angle 90.
  - Assert the lut_en bit for func. Go to WAIT with the counter cleared.
- WAIT:
  - lut_en, lut_quadrant and lut_angle are held stable.
  - The counter increments each cycle. When counter == LUT_LATENCY, capture the selected LUT data into resp_data, deassert lut_en and go to RESP.
- RESP:
  - resp_valid = 1 with resp_data, resp_id and resp_err held stable until resp_valid && resp_ready.
  - Then return to IDLE. A new acceptance is possible from the following cycle, so there is no same-cycle overlap.
- Latency, accept edge to resp_valid rising: q + 3 + LUT_LATENCY cycles for legal requests; 1 cycle for errors.
- lut_en is zero in every state except ISSUE and WAIT, and at most one bit is set.
- Width rules: comparisons and subtraction use DATA_WIDTH unsigned. The q counter is 2 bits and cannot overflow because angles are below 360.

Decomposition:
- Shared package (defines file) holds:
  - function codes CSC = 0, SEC = 1, COT = 2;
  - constants DEG_90 = 90 and DEG_360 = 360;
  - the state encoding.
- One sub-module: trig_rr_arbiter, a 2-way round-robin grant with a pointer register and an update-on-accept input.
- Angle reduction and sequencing stay in the top module.

Test Plan:
- Reset: reset_n low then high → all outputs 0. With both requesters valid, req0_ready is high first.
- req0 csc, angle 30, csc_data model = 0x4000000000000000, LUT_LATENCY = 1:
  - lut_quadrant 0, lut_angle 30, lut_en 3'b001;
  - resp_valid rises 4 cycles after accept with resp_data 0x4000000000000000 and resp_id 0.
- Quadrant mapping for sec at angles 0, 90, 150, 210, 300:
  - (quadrant, lut_angle) = (0,0), (1,90), (1,30), (2,30), (3,60);
  - latencies 4, 5, 5, 6, 7 cycles.
- Arbitration: both requesters valid continuously → grants alternate 0,1,0,1; resp_id follows the same order.
- Errors: angle 360 or func 3 → resp_err 1, resp_data 0, no lut_en pulse, resp_valid rises 1 cycle after accept.
- Backpressure and reset:
  - resp_ready held low for 5 cycles → response held stable and no new grant;
  - reset_n pulsed during WAIT → lut_en and resp_valid drop to 0 immediately and the next request is served normally.
